knns_result_reader: RTL and testbench
=====================================

# knns_result_reader

Sequential reader for the k-nearest-neighbour result list. On `start` it captures the flat K-slot result vector produced by the sequential KNN accumulator and emits the valid entries one per beat, nearest first, over a valid/ready stream. It sits between the KNN accumulator output and the downstream consumer (classifier/vote stage or host port), and drains partially filled lists correctly.

## Interface
- `W`, 32, coordinate width in bits; each entry is `{x[W-1:0], y[W-1:0]}`.
- `K`, 10, number of slots in the result list.
- `CW`, 16, width of the point-count input.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: capture request; sampled only in IDLE.
- `list_in` input 2*W*K: result list. Slot i is `list_in[2*W*(i+1)-1:2*W*i]`; x is the upper W bits and y the lower W bits. Slot 0 is nearest.
- `num_pts` input CW: number of points streamed into the accumulator; sampled with `start`.
- `out_valid` output 1: beat available.
- `out_ready` input 1: consumer accepts the beat.
- `out_x`, `out_y` output W each: coordinates of the current entry.
- `out_idx` output log2(K): slot index of the current entry.
- `out_last` output 1: current beat is the final one.
- `busy` output 1: high outside IDLE.
- `done` output 1: one-cycle pulse after the last beat is accepted, or immediately for an empty list.

## Operation
- States: IDLE and SEND.
- IDLE → SEND when `start` is high and `n = min(num_pts, K) > 0`.
  - `list_in` is latched into an internal 2*W*K register.
  - `n` is latched into `cnt_lim`.
  - `idx` is set to 0.
- IDLE with `start` high and `n = 0`: `done` pulses the next cycle, no beats are emitted, and the block stays in IDLE.
- SEND behaviour:
  - `out_valid` is high.
  - `out_x`/`out_y` come from the captured slot `idx`; `out_idx = idx`; `out_last = (idx == cnt_lim-1)`.
  - A beat is accepted when `out_valid` and `out_ready` are both high. On acceptance, `idx` increments.
  - If the accepted beat has `out_last` high, the block returns to IDLE and pulses `done`.
- `start` in SEND is ignored. The captured list is immune to later `list_in` changes.
- Slots with index ≥ `cnt_lim` hold reset-filler entries and are never emitted.
- `num_pts` ≥ K clamps to K. The comparison is made at CW width, with K zero-extended.

## Timing
- Reset values: state IDLE, `out_valid=0`, `out_x=0`, `out_y=0`, `out_idx=0`, `out_last=0`, `busy=0`, `done=0`, captured list 0, `idx=0`, `cnt_lim=0`.
- `start` at edge t → `out_valid` high in cycle t+1, showing slot 0.
- Throughput is one beat per cycle while `out_ready` is held high. Sending n beats with `out_ready` continuously high takes cycles t+1 … t+n; `done` is high in cycle t+n+1.
- Output data, `out_idx` and `out_last` are registered and stay stable while `out_valid && !out_ready`. No beat is dropped or duplicated.
- `out_ready` may be high before `out_valid`; this has no effect.
- `done` and the next `start` may coincide; the `start` is accepted because the state is already IDLE.
- `rst` asserted mid-SEND: all outputs clear asynchronously and the block returns to IDLE. The partial stream is abandoned and `done` is not pulsed.

## Structure
- The shared knns package/include holds:
  - the `log2` width function used to size `out_idx` and `idx`;
  - the slot-field offset helper, x-upper/y-lower, common with the accumulator.
- Sub-module: `knns_slot_sel`, a combinational K:1 selector of a 2W-bit slot by index, parameterised on W and K. Output registers stay in the parent.
- The FSM, counter and capture register form the parent; no other hierarchy.

## Test plan
W=8, K=4, CW=16 for all scenarios.
- Full list, no backpressure:
  - Stimulus: `list_in` slots 0..3 = {(1,2),(3,4),(5,6),(7,8)}, `num_pts=9`, `start` for one cycle, `out_ready=1`.
  - Required: 4 beats in consecutive cycles, (1,2)…(7,8), `out_idx` 0..3, `out_last` only on (7,8); `done` the cycle after.
- Partial list:
  - Stimulus: `num_pts=2`, slots 2..3 = (0,0).
  - Required: exactly 2 beats (1,2),(3,4); `out_last` on the second; slots 2..3 never appear.
- Empty list:
  - Stimulus: `num_pts=0`.
  - Required: `out_valid` never rises, `busy` stays 0, `done` one cycle after `start`.
- Backpressure and capture isolation:
  - Stimulus: toggle `out_ready` 1,0,0,1,…; change `list_in` and pulse `start` mid-stream.
  - Required: each beat's data holds while stalled; the original 4 entries arrive in order; the second `start` is ignored.
- Reset mid-operation:
  - Stimulus: assert `rst` after beat 1 is accepted.
  - Required: `out_valid`, `busy` and data go 0 immediately, no `done`; a following `start` restarts from slot 0.
- Back-to-back:
  - Stimulus: `start` asserted in the same cycle as `done`.
  - Required: new capture accepted; first beat of the second list appears the next cycle.

Source files
------------

// File: rtl/knns_pkg.sv
// Shared helpers for the knns blocks: index-width function and slot field
// offsets (x in the upper W bits of a slot, y in the lower W bits).
package knns_pkg;

  function automatic int log2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << r) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int slotLo(input int w, input int slot);
    return 2 * w * slot;
  endfunction

  function automatic int slotXLo(input int w, input int slot);
    return slotLo(w, slot) + w;
  endfunction

  function automatic int slotYLo(input int w, input int slot);
    return slotLo(w, slot);
  endfunction

endpackage

// File: rtl/knns_slot_sel.sv
// Combinational K:1 selector returning one 2W-bit slot of a flat result list.
module knns_slot_sel
  import knns_pkg::*;
#(
  parameter int W = 32,
  parameter int K = 10,
  localparam int IW = log2(K)
) (
  input  logic [2*W*K-1:0] list_i,
  input  logic [IW-1:0]    idx_i,
  output logic [2*W-1:0]   slot_o
);

  // Out-of-range indices (K not a power of two) select all zeros.
  always_comb begin
    slot_o = '0;
    for (int i = 0; i < K; i++) begin
      if (idx_i == IW'(i)) slot_o = list_i[slotLo(W, i) +: 2*W];
    end
  end

endmodule

// File: rtl/knns_result_reader.sv
// Captures the KNN result list on start and streams the valid entries,
// nearest first, over a valid/ready interface.
module knns_result_reader
  import knns_pkg::*;
#(
  parameter int W  = 32,
  parameter int K  = 10,
  parameter int CW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2*W*K-1:0]     list_in,
  input  logic [CW-1:0]        num_pts,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         out_x,
  output logic [W-1:0]         out_y,
  output logic [log2(K)-1:0]   out_idx,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done
);

  localparam int IW  = log2(K);
  localparam int CLW = log2(K + 1);
  localparam logic [CW-1:0] K_CW = CW'(K);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  logic [0:0]       stateQ, stateD;
  logic [2*W*K-1:0] listQ, listD;
  logic [IW-1:0]    idxQ, idxD;
  logic [CLW-1:0]   cntLimQ, cntLimD;
  logic [W-1:0]     xQ, xD, yQ, yD;
  logic             lastQ, lastD;
  logic             doneQ, doneD;

  logic             nIsK;
  logic [CLW-1:0]   nLim;
  logic [CLW-1:0]   nextIdxExt;
  logic [2*W*K-1:0] selList;
  logic [IW-1:0]    selIdx;
  logic [2*W-1:0]   selSlot;

  assign nIsK = (num_pts >= K_CW);
  assign nLim = nIsK ? CLW'(K) : num_pts[CLW-1:0];
  assign nextIdxExt = CLW'(idxQ) + CLW'(1);

  // In IDLE the first beat is taken straight from list_in so it is ready the
  // cycle after start; in SEND we look one slot ahead of the current beat.
  assign selList = (stateQ == ST_IDLE) ? list_in : listQ;
  assign selIdx  = (stateQ == ST_IDLE) ? '0 : idxQ + IW'(1);

  knns_slot_sel #(.W(W), .K(K)) uSlotSel (
    .list_i (selList),
    .idx_i  (selIdx),
    .slot_o (selSlot)
  );

  always_comb begin
    stateD  = stateQ;
    listD   = listQ;
    idxD    = idxQ;
    cntLimD = cntLimQ;
    xD      = xQ;
    yD      = yQ;
    lastD   = lastQ;
    doneD   = 1'b0;
    case (stateQ)
      ST_IDLE: begin
        if (start) begin
          if (nIsK || (num_pts != '0)) begin
            stateD  = ST_SEND;
            listD   = list_in;
            cntLimD = nLim;
            idxD    = '0;
            xD      = selSlot[W +: W];
            yD      = selSlot[0 +: W];
            lastD   = (nLim == CLW'(1));
          end else begin
            doneD = 1'b1;
          end
        end
      end
      ST_SEND: begin
        if (out_ready) begin
          if (lastQ) begin
            stateD = ST_IDLE;
            idxD   = '0;
            xD     = '0;
            yD     = '0;
            lastD  = 1'b0;
            doneD  = 1'b1;
          end else begin
            idxD  = idxQ + IW'(1);
            xD    = selSlot[W +: W];
            yD    = selSlot[0 +: W];
            lastD = ((nextIdxExt + CLW'(1)) == cntLimQ);
          end
        end
      end
      default: stateD = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ  <= ST_IDLE;
      listQ   <= '0;
      idxQ    <= '0;
      cntLimQ <= '0;
      xQ      <= '0;
      yQ      <= '0;
      lastQ   <= 1'b0;
      doneQ   <= 1'b0;
    end else begin
      stateQ  <= stateD;
      listQ   <= listD;
      idxQ    <= idxD;
      cntLimQ <= cntLimD;
      xQ      <= xD;
      yQ      <= yD;
      lastQ   <= lastD;
      doneQ   <= doneD;
    end
  end

  assign out_valid = (stateQ == ST_SEND);
  assign busy      = (stateQ == ST_SEND);
  assign out_x     = xQ;
  assign out_y     = yQ;
  assign out_idx   = idxQ;
  assign out_last  = lastQ;
  assign done      = doneQ;

endmodule

// File: tb/tb_knns_result_reader.sv
// Bench for knns_result_reader: a queue model of the expected beat stream is
// compared every cycle, and directed scenarios pin it with literal values.
module tb_knns_result_reader;

  localparam int W  = 8;
  localparam int K  = 4;
  localparam int CW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [2*W*K-1:0] list_in;
  logic [CW-1:0]   num_pts;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_x;
  logic [W-1:0]    out_y;
  logic [1:0]      out_idx;
  logic            out_last;
  logic            busy;
  logic            done;

  always #5 clk = ~clk;

  knns_result_reader #(.W(W), .K(K), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .list_in   (list_in),
    .num_pts   (num_pts),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic [1:0] idx;
    logic       last;
  } beat_t;

  beat_t       expQ[$];
  bit          expDone;
  bit          compareEn;
  logic [15:0] acceptLog[$];
  int          checks   = 0;
  int          failures = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Model: a started list becomes a queue of the first min(num_pts,K) slots.
  always @(posedge clk or posedge rst) begin : model
    int n;
    beat_t b;
    if (rst) begin
      expQ.delete();
      expDone = 1'b0;
    end else begin
      expDone = 1'b0;
      if (expQ.size() != 0) begin
        if (out_ready) begin
          if (expQ.size() == 1) expDone = 1'b1;
          void'(expQ.pop_front());
        end
      end else if (start) begin
        n = (num_pts >= 16'd4) ? 4 : int'(num_pts);
        if (n == 0) expDone = 1'b1;
        for (int i = 0; i < n; i++) begin
          b.x    = list_in[16*i+8 +: 8];
          b.y    = list_in[16*i +: 8];
          b.idx  = 2'(i);
          b.last = (i == n - 1);
          expQ.push_back(b);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (compareEn) begin
      checkOutput("valid", out_valid, expQ.size() != 0);
      checkOutput("busy", busy, expQ.size() != 0);
      checkOutput("done", done, expDone);
      if (expQ.size() != 0 && out_valid) begin
        checkOutput("beatX", out_x, expQ[0].x);
        checkOutput("beatY", out_y, expQ[0].y);
        checkOutput("beatIdx", out_idx, expQ[0].idx);
        checkOutput("beatLast", out_last, expQ[0].last);
      end
    end
  end

  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) acceptLog.push_back({out_x, out_y});
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic loadList(input logic [15:0] s0, input logic [15:0] s1, input logic [15:0] s2, input logic [15:0] s3);
    list_in = {s3, s2, s1, s0};
  endtask

  task automatic applyStimulus(input logic [15:0] numPts);
    num_pts = numPts;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic waitDone(input int maxCycles, output int cycles);
    cycles = 0;
    while (!done && cycles < maxCycles) begin
      tick();
      cycles++;
    end
    if (!done) checkOutput("doneTimeout", 0, 1);
  endtask

  task automatic checkLog(input string name, input int n, input logic [15:0] e0, input logic [15:0] e1,
                          input logic [15:0] e2, input logic [15:0] e3);
    logic [15:0] e[4];
    e = '{e0, e1, e2, e3};
    checkOutput({name, "Count"}, acceptLog.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < acceptLog.size()) checkOutput({name, "Entry"}, acceptLog[i], e[i]);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc;
    bit seenDone;
    rst = 1'b1; start = 1'b0; out_ready = 1'b0; num_pts = '0; list_in = '0; compareEn = 1'b0;
    #1;
    checkOutput("rstValid", out_valid, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstX", out_x, 0);
    checkOutput("rstY", out_y, 0);
    checkOutput("rstIdx", out_idx, 0);
    checkOutput("rstLast", out_last, 0);
    checkOutput("rstDone", done, 0);
    tick(); tick();
    rst = 1'b0;
    compareEn = 1'b1;
    tick();

    // Full list, num_pts clamps to K.
    loadList({8'd1, 8'd2}, {8'd3, 8'd4}, {8'd5, 8'd6}, {8'd7, 8'd8});
    out_ready = 1'b1;
    acceptLog.delete();
    applyStimulus(16'd9);
    checkOutput("fullFirstX", out_x, 1);
    checkOutput("fullFirstY", out_y, 2);
    checkOutput("fullFirstIdx", out_idx, 0);
    checkOutput("fullFirstLast", out_last, 0);
    waitDone(20, cyc);
    checkOutput("fullCycles", cyc, 4);
    checkLog("full", 4, 16'h0102, 16'h0304, 16'h0506, 16'h0708);
    tick();

    // Partial list.
    loadList({8'd1, 8'd2}, {8'd3, 8'd4}, 16'h0000, 16'h0000);
    acceptLog.delete();
    applyStimulus(16'd2);
    waitDone(20, cyc);
    checkOutput("partCycles", cyc, 2);
    checkLog("part", 2, 16'h0102, 16'h0304, 16'h0, 16'h0);
    tick();

    // Empty list.
    acceptLog.delete();
    applyStimulus(16'd0);
    checkOutput("emptyDone", done, 1);
    checkOutput("emptyValid", out_valid, 0);
    checkOutput("emptyBusy", busy, 0);
    tick();
    checkOutput("emptyDoneClear", done, 0);
    checkOutput("emptyBeats", acceptLog.size(), 0);

    // Backpressure with a mid-stream list change and ignored start.
    loadList({8'd10, 8'd11}, {8'd12, 8'd13}, {8'd14, 8'd15}, {8'd16, 8'd17});
    out_ready = 1'b0;
    acceptLog.delete();
    applyStimulus(16'd4);
    seenDone = 1'b0;
    for (int k = 0; k < 40 && !seenDone; k++) begin
      out_ready = (k % 4 == 0) || (k % 4 == 3);
      if (k == 2) begin
        loadList(16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD);
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      seenDone = done;
    end
    start = 1'b0;
    checkOutput("bpDone", seenDone, 1);
    checkLog("bp", 4, 16'h0A0B, 16'h0C0D, 16'h0E0F, 16'h1011);
    out_ready = 1'b1;
    tick(); tick();
    checkOutput("bpNoRestart", out_valid, 0);
    checkOutput("bpNoExtraBeats", acceptLog.size(), 4);

    // Reset mid-stream after the first beat is accepted.
    loadList({8'd1, 8'd2}, {8'd3, 8'd4}, {8'd5, 8'd6}, {8'd7, 8'd8});
    acceptLog.delete();
    applyStimulus(16'd4);
    tick();
    checkOutput("rstMidAccepted", acceptLog.size(), 1);
    checkOutput("rstMidShowsIdx1", out_idx, 1);
    rst = 1'b1;
    #1;
    checkOutput("rstMidValid", out_valid, 0);
    checkOutput("rstMidBusy", busy, 0);
    checkOutput("rstMidX", out_x, 0);
    checkOutput("rstMidY", out_y, 0);
    checkOutput("rstMidIdx", out_idx, 0);
    checkOutput("rstMidDone", done, 0);
    tick();
    rst = 1'b0;
    tick();
    acceptLog.delete();
    applyStimulus(16'd4);
    checkOutput("restartIdx", out_idx, 0);
    checkOutput("restartX", out_x, 1);
    checkOutput("restartY", out_y, 2);
    waitDone(20, cyc);
    checkOutput("restartCycles", cyc, 4);
    checkLog("restart", 4, 16'h0102, 16'h0304, 16'h0506, 16'h0708);
    tick();

    // Back-to-back: new start in the done cycle.
    loadList({8'd1, 8'd2}, {8'd3, 8'd4}, 16'h0000, 16'h0000);
    applyStimulus(16'd2);
    waitDone(20, cyc);
    checkOutput("b2bFirstCycles", cyc, 2);
    loadList({8'd21, 8'd22}, 16'h0000, 16'h0000, 16'h0000);
    applyStimulus(16'd1);
    checkOutput("b2bValid", out_valid, 1);
    checkOutput("b2bX", out_x, 21);
    checkOutput("b2bY", out_y, 22);
    checkOutput("b2bIdx", out_idx, 0);
    checkOutput("b2bLast", out_last, 1);
    tick();
    checkOutput("b2bDone", done, 1);
    tick();

    compareEn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
